// File: rtl/lector_destinos_externos.sv
// lector_destinos_externos
//
// Sequential reader for the external-destination queue ROM. A start pulse
// walks the ROM address from 0 to DEPTH-1. Each combinational ROM word is
// latched and then offered to the elevator controller over a valid/ready
// handshake.
//
// Optional feature macro: DEDUP_EN.
//   When defined, a fetched word whose floor code [1:0] matches the floor
//   code of the last delivered word is skipped without an offer cycle.
//   The "last delivered" record is cleared by reset and by every start.
//
// Ports:
//   clk        in   rising-edge system clock
//   reset      in   asynchronous, active-high reset
//   start      in   one-cycle pass request, honoured only while idle
//   loop       in   sampled at end of pass: 1 = restart at 0, 0 = finish
//   address    out  ROM address (the registered read pointer)
//   destino    in   ROM data for the current address
//   dest_data  out  latched destination word offered to the consumer
//   dest_valid out  dest_data holds an undelivered word
//   dest_ready in   consumer accepts dest_data this cycle
//   busy       out  high in every state except IDLE
//   done       out  one-cycle pulse when a non-looping pass completes
module lector_destinos_externos #(
  parameter int DEPTH  = 10,
  parameter int ADDR_W = 8,
  parameter int DEST_W = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              loop,
  output logic [ADDR_W-1:0] address,
  input  logic [DEST_W-1:0] destino,
  output logic [DEST_W-1:0] dest_data,
  output logic              dest_valid,
  input  logic              dest_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    OFFER = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] PTR_ZERO = ADDR_W'(0);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [DEST_W-1:0]   dest_data_q, dest_data_d;
  logic                dest_valid_q, dest_valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // Where the walk goes once the current entry is finished (delivered or skipped).
  state_t              adv_state;
  logic [ADDR_W-1:0]   adv_ptr;

`ifdef DEDUP_EN
  logic [1:0]          last_floor_q, last_floor_d;
  logic                last_vld_q, last_vld_d;
`endif

  // Advance rule: explicit wrap at DEPTH-1, never modular overflow of ptr.
  always_comb begin
    adv_state = FETCH;
    adv_ptr   = ptr_q;
    if (ptr_q == LAST_PTR) begin
      if (loop) begin
        adv_state = FETCH;
        adv_ptr   = PTR_ZERO;
      end else begin
        adv_state = DONE;
        adv_ptr   = ptr_q;
      end
    end else begin
      adv_state = FETCH;
      adv_ptr   = ptr_q + PTR_ONE;
    end
  end

  // Next-state, next-pointer, data latch and registered output decode.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    dest_data_d = dest_data_q;
`ifdef DEDUP_EN
    last_floor_d = last_floor_q;
    last_vld_d   = last_vld_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          ptr_d   = PTR_ZERO;
`ifdef DEDUP_EN
          last_vld_d = 1'b0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      FETCH: begin
`ifdef DEDUP_EN
        // A repeat of the last delivered floor is dropped with no offer cycle.
        if (last_vld_q && (destino[1:0] == last_floor_q)) begin
          state_d = adv_state;
          ptr_d   = adv_ptr;
        end else begin
          dest_data_d = destino;
          state_d     = OFFER;
        end
`else
        dest_data_d = destino;
        state_d     = OFFER;
`endif
      end
      OFFER: begin
        if (dest_ready) begin
          state_d = adv_state;
          ptr_d   = adv_ptr;
`ifdef DEDUP_EN
          last_floor_d = dest_data_q[1:0];
          last_vld_d   = 1'b1;
`endif
        end else begin
          state_d = OFFER;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they come straight off flops.
    busy_d       = (state_d != IDLE);
    dest_valid_d = (state_d == OFFER);
    done_d       = (state_d == DONE);
  end

  // State, pointer and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      ptr_q        <= PTR_ZERO;
      dest_data_q  <= {DEST_W{1'b0}};
      dest_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef DEDUP_EN
      last_floor_q <= 2'b00;
      last_vld_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      dest_data_q  <= dest_data_d;
      dest_valid_q <= dest_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef DEDUP_EN
      last_floor_q <= last_floor_d;
      last_vld_q   <= last_vld_d;
`endif
    end
  end

  assign address    = ptr_q;
  assign dest_data  = dest_data_q;
  assign dest_valid = dest_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
